// File: rtl/sap_cpu_core.sv
// sap_cpu_core: parametrised SAP-style accumulator CPU with a program-load port.
// Fixed three-cycle instruction timing: fetch (T1), operand read (T2), execute (T3).
// Define SAP_CALL_EN to add single-level CALL (opcode 9) and RET (opcode A).
module sap_cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic              flag_c,
   output logic              flag_z
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
`ifdef SAP_CALL_EN
   localparam logic [3:0] OP_CALL = 4'h9;
   localparam logic [3:0] OP_RET  = 4'hA;
`endif
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T3,
      S_HALT
   } state_t;

   state_t state, state_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] acc, acc_d;
   logic [DATA_W-1:0] ir, ir_d;
   logic [DATA_W-1:0] mdr, mdr_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic              valid_q, valid_d;
`ifdef SAP_CALL_EN
   logic [ADDR_W-1:0] rr, rr_d;
`endif

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;

   assign opcode  = ir[DATA_W-1 -: 4];
   assign operand = ir[ADDR_W-1:0];
   assign sum     = {1'b0, acc} + {1'b0, mdr};
   assign diff    = acc - mdr;

   // Next-state and datapath decode; dropping run in any T-state aborts with no writeback.
   always_comb begin
      state_d   = state;
      pc_d      = pc_q;
      acc_d     = acc;
      ir_d      = ir;
      mdr_d     = mdr;
      c_d       = c_q;
      z_d       = z_q;
      out_d     = out_q;
      valid_d   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = prog_addr;
      mem_wdata = prog_data;
`ifdef SAP_CALL_EN
      rr_d      = rr;
`endif
      case (state)
         S_IDLE: begin
            if (run) begin
               pc_d    = '0;
               state_d = S_T1;
            end else if (prog_we) begin
               mem_we = 1'b1;
            end
         end
         S_T1: begin
            if (!run) begin
               state_d = S_IDLE;
            end else begin
               ir_d    = mem[pc_q];
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_T2;
            end
         end
         S_T2: begin
            if (!run) begin
               state_d = S_IDLE;
            end else begin
               mdr_d   = mem[operand];
               state_d = S_T3;
            end
         end
         S_T3: begin
            if (!run) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_T1;
               case (opcode)
                  OP_LDA: begin
                     acc_d = mdr;
                     z_d   = (mdr == '0);
                  end
                  OP_ADD: begin
                     acc_d = sum[DATA_W-1:0];
                     c_d   = sum[DATA_W];
                     z_d   = (sum[DATA_W-1:0] == '0);
                  end
                  OP_SUB: begin
                     acc_d = diff;
                     c_d   = (acc >= mdr);
                     z_d   = (diff == '0);
                  end
                  OP_STA: begin
                     mem_we    = 1'b1;
                     mem_waddr = operand;
                     mem_wdata = acc;
                  end
                  OP_LDI: begin
                     acc_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
                     z_d   = (operand == '0);
                  end
                  OP_JMP: pc_d = operand;
                  OP_JC:  if (c_q) pc_d = operand;
                  OP_JZ:  if (z_q) pc_d = operand;
`ifdef SAP_CALL_EN
                  OP_CALL: begin
                     rr_d = pc_q;
                     pc_d = operand;
                  end
                  OP_RET: pc_d = rr;
`endif
                  OP_OUT: begin
                     out_d   = acc;
                     valid_d = 1'b1;
                  end
                  OP_HLT: state_d = S_HALT;
                  default: ;
               endcase
            end
         end
         S_HALT: begin
            if (!run) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; ena=0 freezes the sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else if (ena) begin
         state <= state_d;
      end
   end

   // Architectural registers, all held while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= '0;
         acc   <= '0;
         ir    <= '0;
         mdr   <= '0;
         c_q   <= 1'b0;
         z_q   <= 1'b0;
         out_q <= '0;
`ifdef SAP_CALL_EN
         rr    <= '0;
`endif
      end else if (ena) begin
         pc_q  <= pc_d;
         acc   <= acc_d;
         ir    <= ir_d;
         mdr   <= mdr_d;
         c_q   <= c_d;
         z_q   <= z_d;
         out_q <= out_d;
`ifdef SAP_CALL_EN
         rr    <= rr_d;
`endif
      end
   end

   // Output strobe clears on every edge so it can never stretch past one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= ena & valid_d;
      end
   end

   // Program RAM: synchronous write from the load port or STA, never reset.
   always_ff @(posedge clk) begin
      if (ena && mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign out_data  = out_q;
   assign out_valid = valid_q & ena;
   assign halted    = (state == S_HALT);
   assign pc        = pc_q;
   assign flag_c    = c_q;
   assign flag_z    = z_q;

endmodule

// File: tb/tb_sap_cpu_core.sv
// tb_sap_cpu_core: directed and random programs checked against an instruction-level model.
module tb_sap_cpu_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       run;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       halted;
   logic [3:0] pc;
   logic       flag_c;
   logic       flag_z;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] img [16];

   // Instruction-level reference state
   logic [7:0] m_mem [16];
   logic [7:0] m_a;
   logic [7:0] m_out;
   logic [3:0] m_pc;
   logic [3:0] m_rr;
   logic       m_c;
   logic       m_z;
   logic       m_halt;
   logic       m_outv;

   sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .run       (run),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted),
      .pc        (pc),
      .flag_c    (flag_c),
      .flag_z    (flag_z)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_a = 8'h00; m_out = 8'h00; m_pc = 4'h0; m_rr = 4'h0;
      m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_outv = 1'b0;
   endtask

   // Execute one whole instruction on the reference state.
   task automatic model_step();
      int instr, op, opd, val, res;
      instr = int'(m_mem[m_pc]);
      op = instr / 16;
      opd = instr % 16;
      val = int'(m_mem[opd]);
      m_pc = m_pc + 4'd1;
      m_outv = 1'b0;
      case (op)
         1: begin m_a = 8'(val); m_z = (m_a == 8'h00); end
         2: begin res = int'(m_a) + val; m_c = (res > 255); m_a = 8'(res); m_z = (m_a == 8'h00); end
         3: begin m_c = (int'(m_a) >= val); m_a = 8'(int'(m_a) - val); m_z = (m_a == 8'h00); end
         4: m_mem[opd] = m_a;
         5: begin m_a = 8'(opd); m_z = (m_a == 8'h00); end
         6: m_pc = 4'(opd);
         7: if (m_c) m_pc = 4'(opd);
         8: if (m_z) m_pc = 4'(opd);
`ifdef SAP_CALL_EN
         9: begin m_rr = m_pc; m_pc = 4'(opd); end
         10: m_pc = m_rr;
`endif
         14: begin m_out = m_a; m_outv = 1'b1; end
         15: m_halt = 1'b1;
         default: ;
      endcase
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; run = 1'b0; ena = 1'b1; prog_we = 1'b0;
      prog_addr = 4'h0; prog_data = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic clear_image();
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
   endtask

   task automatic load_image();
      for (int i = 0; i < 16; i++) begin
         prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
         @(negedge clk);
         m_mem[i] = img[i];
      end
      prog_we = 1'b0;
   endtask

   task automatic start_run();
      run = 1'b1;
      @(negedge clk);
      m_pc = 4'h0;
      m_halt = 1'b0;
      m_outv = 1'b0;
   endtask

   // Three cycles per instruction; out_valid must stay low except after T3.
   task automatic run_instr(input string tag);
      model_step();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k < 2) begin
            vectors++;
            if (out_valid !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL %s out_valid mid-instruction got %b expected 0", tag, out_valid);
            end
         end
      end
      vectors++;
      if ({pc, flag_c, flag_z, out_data, out_valid, halted} !== {m_pc, m_c, m_z, m_out, m_outv, m_halt}) begin
         miscompares++;
         $display("[TB] FAIL %s got pc=%h c=%b z=%b out=%h v=%b h=%b expected pc=%h c=%b z=%b out=%h v=%b h=%b",
                  tag, pc, flag_c, flag_z, out_data, out_valid, halted, m_pc, m_c, m_z, m_out, m_outv, m_halt);
      end
   endtask

   task automatic run_program(input int max_instr, input string tag);
      for (int i = 0; i < max_instr && !m_halt; i++) run_instr(tag);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({pc, flag_c, flag_z, out_data, out_valid, halted} !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL reset_values got pc=%h c=%b z=%b out=%h v=%b h=%b expected all 0",
                  pc, flag_c, flag_z, out_data, out_valid, halted);
      end
      clear_image();
      img[0] = 8'h55; img[1] = 8'hE0; img[2] = 8'h61;
      load_image();
      start_run();
      run_instr("rst_pre");
      run_instr("rst_pre");
      #2;
      rst_n = 1'b0;
      run = 1'b0;
      #1;
      vectors++;
      if ({pc, flag_c, flag_z, out_data, out_valid, halted} !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL reset_midrun got pc=%h c=%b z=%b out=%h v=%b h=%b expected all 0",
                  pc, flag_c, flag_z, out_data, out_valid, halted);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      start_run();
      run_program(3, "rst_ram_kept");
   endtask

   task automatic test_load_run_out();
      do_reset();
      clear_image();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
      img[14] = 8'h1C; img[15] = 8'h0E;
      load_image();
      start_run();
      run_program(4, "lro");
      vectors++;
      if ({out_data, halted, pc} !== {8'h2A, 1'b1, 4'h4}) begin
         miscompares++;
         $display("[TB] FAIL lro_final got out=%h h=%b pc=%h expected out=2a h=1 pc=4", out_data, halted, pc);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if ({halted, pc, out_valid} !== {1'b1, 4'h4, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL lro_hold got h=%b pc=%h v=%b expected h=1 pc=4 v=0", halted, pc, out_valid);
         end
      end
      run = 1'b0;
      @(negedge clk);
      vectors++;
      if (halted !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL lro_leave_halt got h=%b expected 0", halted);
      end
   endtask

   task automatic test_carry_jc();
      do_reset();
      clear_image();
      img[0] = 8'h1C; img[1] = 8'h2D; img[2] = 8'h78; img[3] = 8'hF0;
      img[8] = 8'hE0; img[9] = 8'hF0; img[12] = 8'hF0; img[13] = 8'h20;
      load_image();
      start_run();
      for (int i = 0; i < 3; i++) run_instr("cj");
      vectors++;
      if ({pc, flag_c, flag_z} !== {4'h8, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL cj_branch got pc=%h c=%b z=%b expected pc=8 c=1 z=0", pc, flag_c, flag_z);
      end
      run_program(4, "cj");
      vectors++;
      if ({out_data, halted} !== {8'h10, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL cj_out got out=%h h=%b expected out=10 h=1", out_data, halted);
      end
   endtask

   task automatic test_sub_jz();
      logic [7:0] sv;
      logic       taken;
      for (int r = 0; r < 2; r++) begin
         sv = (r == 0) ? 8'h05 : 8'h06;
         taken = (r == 0);
         do_reset();
         clear_image();
         img[0] = 8'h55; img[1] = 8'h3C; img[2] = 8'h88; img[3] = 8'hE0; img[4] = 8'hF0;
         img[8] = 8'hE0; img[9] = 8'hF0; img[12] = sv;
         load_image();
         start_run();
         for (int i = 0; i < 3; i++) run_instr("sz");
         vectors++;
         if ({pc, flag_c, flag_z} !== {(taken ? 4'h8 : 4'h3), taken, taken}) begin
            miscompares++;
            $display("[TB] FAIL sz_branch sub=%h got pc=%h c=%b z=%b expected pc=%h c=%b z=%b",
                     sv, pc, flag_c, flag_z, (taken ? 4'h8 : 4'h3), taken, taken);
         end
         run_program(4, "sz");
         vectors++;
         if (out_data !== (taken ? 8'h00 : 8'hFF)) begin
            miscompares++;
            $display("[TB] FAIL sz_result sub=%h got out=%h expected %h", sv, out_data, (taken ? 8'h00 : 8'hFF));
         end
      end
   endtask

   task automatic test_pc_wrap();
      int exp_pc;
      logic exp_v;
      do_reset();
      clear_image();
      img[0] = 8'hE0;
      load_image();
      start_run();
      for (int k = 1; k <= 110; k++) begin
         @(negedge clk);
         exp_pc = (((k - 1) / 3) + 1) % 16;
         exp_v = ((k % 48) == 3);
         vectors++;
         if ({pc, out_valid} !== {4'(exp_pc), exp_v}) begin
            miscompares++;
            $display("[TB] FAIL wrap cycle %0d got pc=%h v=%b expected pc=%h v=%b", k, pc, out_valid, 4'(exp_pc), exp_v);
         end
      end
   endtask

   task automatic test_abort_gating();
      do_reset();
      clear_image();
      img[0] = 8'h57; img[1] = 8'h4C; img[2] = 8'hF0; img[12] = 8'h33;
      load_image();
      start_run();
      run_instr("ab_ldi");
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      vectors++;
      if ({halted, pc} !== {1'b0, 4'h2}) begin
         miscompares++;
         $display("[TB] FAIL abort_state got h=%b pc=%h expected h=0 pc=2", halted, pc);
      end
      // read back the STA target
      img[0] = 8'h1C; img[1] = 8'hE0; img[2] = 8'hF0;
      load_image();
      start_run();
      run_program(3, "ab_read");
      vectors++;
      if (out_data !== 8'h33) begin
         miscompares++;
         $display("[TB] FAIL abort_ram got out=%h expected 33", out_data);
      end
      // prog_we while running must not write
      run = 1'b0;
      @(negedge clk);
      img[0] = 8'h1D; img[1] = 8'hE0; img[2] = 8'hF0; img[13] = 8'h44;
      load_image();
      prog_we = 1'b1; prog_addr = 4'hD; prog_data = 8'h99;
      start_run();
      run_program(3, "pw_run");
      prog_we = 1'b0;
      vectors++;
      if (out_data !== 8'h44) begin
         miscompares++;
         $display("[TB] FAIL prog_we_running got out=%h expected 44", out_data);
      end
      // ena low mid-instruction freezes everything
      run = 1'b0;
      @(negedge clk);
      img[0] = 8'h59; img[1] = 8'h2C; img[2] = 8'hE0; img[3] = 8'hF0; img[12] = 8'h01;
      load_image();
      start_run();
      run_instr("en_ldi");
      @(negedge clk);
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vectors++;
         if ({pc, flag_z, out_valid, halted} !== {4'h2, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL ena_freeze got pc=%h z=%b v=%b h=%b expected pc=2 z=0 v=0 h=0",
                     pc, flag_z, out_valid, halted);
         end
      end
      ena = 1'b1;
      repeat (2) @(negedge clk);
      model_step();
      vectors++;
      if ({pc, flag_c, flag_z} !== {m_pc, m_c, m_z}) begin
         miscompares++;
         $display("[TB] FAIL ena_resume got pc=%h c=%b z=%b expected pc=%h c=%b z=%b",
                  pc, flag_c, flag_z, m_pc, m_c, m_z);
      end
      run_program(2, "en_tail");
      vectors++;
      if (out_data !== 8'h0A) begin
         miscompares++;
         $display("[TB] FAIL ena_result got out=%h expected 0a", out_data);
      end
   endtask

   task automatic test_call();
      do_reset();
      clear_image();
      img[0] = 8'h53; img[1] = 8'h00; img[2] = 8'h9A; img[3] = 8'hE0; img[4] = 8'hF0;
      img[10] = 8'hE0; img[11] = 8'hA0;
      load_image();
      start_run();
      for (int i = 0; i < 3; i++) run_instr("call");
`ifdef SAP_CALL_EN
      vectors++;
      if (pc !== 4'hA) begin
         miscompares++;
         $display("[TB] FAIL call_target got pc=%h expected a", pc);
      end
      run_instr("call_sub");
      run_instr("call_ret");
      vectors++;
      if (pc !== 4'h3) begin
         miscompares++;
         $display("[TB] FAIL call_return got pc=%h expected 3", pc);
      end
`else
      vectors++;
      if (pc !== 4'h3) begin
         miscompares++;
         $display("[TB] FAIL call_as_nop got pc=%h expected 3", pc);
      end
`endif
      run_program(6, "call_tail");
      vectors++;
      if ({out_data, halted, pc} !== {8'h03, 1'b1, 4'h5}) begin
         miscompares++;
         $display("[TB] FAIL call_final got out=%h h=%b pc=%h expected out=03 h=1 pc=5", out_data, halted, pc);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         do_reset();
         for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
         load_image();
         start_run();
         run_program(30, "random");
      end
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; ena = 1'b1; prog_we = 1'b0;
      prog_addr = 4'h0; prog_data = 8'h00;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      model_reset();
      test_reset();
      test_load_run_out();
      test_carry_jc();
      test_sub_jz();
      test_pc_wrap();
      test_abort_gating();
      test_call();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
